// File: rtl/instr_fetch.sv
`default_nettype none
// =============================================================================
// instr_fetch : owns the PC and fetches words from instruction memory over req/ack,
//               then holds each instruction for decode behind a valid/ready handshake.
// Revision    : 1.0
// =============================================================================
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] pcplus4,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic [31:0] redir_pc;
  logic [31:0] drain_target;

  assign redir_pc = redirect_pc & ~32'h0000_0003;

  // A redirect landing in the same cycle as the draining ack must still win.
  assign drain_target = redirect_valid ? redir_pc : pend_pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      pend_pc  <= 32'h0000_0000;
      instr    <= 32'h0000_0000;
      instr_pc <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_valid) pc <= redir_pc;
          state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            if (redirect_valid) begin
              pc <= redir_pc;
            end else begin
              instr    <= imem_rdata;
              instr_pc <= pc;
              state    <= HOLD;
            end
          end else if (redirect_valid) begin
            pend_pc <= redir_pc;
            state   <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect_valid) pend_pc <= redir_pc;
          if (imem_ack) begin
            pc    <= drain_target;
            state <= FETCH;
          end
        end
        HOLD: begin
          if (redirect_valid) begin
            pc    <= redir_pc;
            state <= FETCH;
          end else if (instr_ready) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decoded straight from state so an asynchronous reset drops the request at once.
  assign imem_req    = (state == FETCH) || (state == DRAIN);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign pcplus4     = instr_pc + 32'd4;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// =============================================================================
// tb_instr_fetch : directed self-checking bench for instr_fetch.
// Revision       : 1.0
// =============================================================================
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] pcplus4;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int total = 0;
  int bad = 0;

  logic mem_hold = 1'b0;
  int   mem_wait = 0;
  int   wait_cnt = 0;

  instr_fetch #(.RESET_PC(32'h0000_0040)) dut (
    .clk(clk), .reset_n(reset_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .pcplus4(pcplus4),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a == 32'h40) ? 32'h8C08_0004 : {8'h20, a[23:0]};
  endfunction

  assign imem_ack   = imem_req && !mem_hold && (wait_cnt >= mem_wait);
  assign imem_rdata = word_at(imem_addr);

  always @(posedge clk) wait_cnt <= (imem_req && !imem_ack) ? wait_cnt + 1 : 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; mem_wait = 0;
    tick; tick;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", imem_req); end
    total++; if (imem_addr !== 32'h40) begin bad++; $display("FAIL reset_addr got=%h want=00000040", imem_addr); end
    total++; if (instr_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", instr_valid); end
    total++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h/%h want=0/0", instr, instr_pc); end
    reset_n = 1'b1;
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin bad++; $display("FAIL boot_req got=%b/%h want=1/00000040", imem_req, imem_addr); end
    tick;
    total++; if (instr_valid !== 1'b1 || instr !== 32'h8C08_0004) begin bad++; $display("FAIL boot_instr got=%b/%h want=1/8c080004", instr_valid, instr); end
    total++; if (instr_pc !== 32'h40 || pcplus4 !== 32'h44) begin bad++; $display("FAIL boot_pc got=%h/%h want=00000040/00000044", instr_pc, pcplus4); end
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL boot_hold_req got=%b want=0", imem_req); end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc [3];
    logic [31:0] exp_in [3];
    int k;
    exp_pc = '{32'h40, 32'h44, 32'h48};
    exp_in = '{32'h8C08_0004, 32'h2000_0044, 32'h2000_0048};
    k = 0;
    reset_n = 1'b0; mem_wait = 2;
    tick;
    reset_n = 1'b1; instr_ready = 1'b1;
    for (int c = 0; c < 40 && k < 3; c++) begin
      tick;
      if (imem_req) begin
        total++;
        if (imem_addr !== exp_pc[k]) begin bad++; $display("FAIL stream_addr got=%h want=%h", imem_addr, exp_pc[k]); end
      end
      if (instr_valid) begin
        total++;
        if (instr_pc !== exp_pc[k] || instr !== exp_in[k]) begin
          bad++; $display("FAIL stream_word got=%h/%h want=%h/%h", instr_pc, instr, exp_pc[k], exp_in[k]);
        end
        k++;
      end
    end
    total++; if (k != 3) begin bad++; $display("FAIL stream_count got=%0d want=3", k); end
    tick;
    instr_ready = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h4C) begin bad++; $display("FAIL stream_next got=%b/%h want=1/0000004c", imem_req, imem_addr); end
  endtask

  task automatic test_backpressure;
    int c;
    c = 0;
    while (!instr_valid && c < 10) begin tick; c++; end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h4C || instr !== 32'h2000_004C) begin
      bad++; $display("FAIL bp_arrive got=%b/%h/%h want=1/0000004c/2000004c", instr_valid, instr_pc, instr);
    end
    for (int i = 0; i < 5; i++) begin
      tick;
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h4C || instr !== 32'h2000_004C || imem_req !== 1'b0) begin
        bad++; $display("FAIL bp_stall got=%b/%h/%h req=%b want=1/0000004c/2000004c req=0", instr_valid, instr_pc, instr, imem_req);
      end
    end
    instr_ready = 1'b1;
    tick;
    instr_ready = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h50 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL bp_release got=%b/%h v=%b want=1/00000050 v=0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect_drain;
    int c;
    mem_hold = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    tick;
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h50 || instr_valid !== 1'b0) begin
        bad++; $display("FAIL drain_hold got=%b/%h v=%b want=1/00000050 v=0", imem_req, imem_addr, instr_valid);
      end
      tick;
    end
    mem_hold = 1'b0;
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL drain_target got=%b/%h v=%b want=1/00000100 v=0", imem_req, imem_addr, instr_valid);
    end
    mem_hold = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick;
    redirect_valid = 1'b0;
    tick;
    total++; if (imem_addr !== 32'h100 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL drain2_hold got=%h v=%b want=00000100 v=0", imem_addr, instr_valid);
    end
    redirect_valid = 1'b1; redirect_pc = 32'h404; mem_hold = 1'b0;
    tick;
    redirect_valid = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin
      bad++; $display("FAIL drain_latest got=%b/%h want=1/00000404", imem_req, imem_addr);
    end
    c = 0;
    while (!instr_valid && c < 10) begin tick; c++; end
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h404 || instr !== 32'h2000_0404) begin
      bad++; $display("FAIL drain_after got=%b/%h/%h want=1/00000404/20000404", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_hold_redirect;
    mem_wait = 0; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick;
    instr_ready = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL hold_redirect got=%b/%h v=%b want=1/00000200 v=0", imem_req, imem_addr, instr_valid);
    end
    redirect_pc = 32'h600;
    tick;
    redirect_valid = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h600 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL ack_redirect got=%b/%h v=%b want=1/00000600 v=0", imem_req, imem_addr, instr_valid);
    end
    tick;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h600 || instr !== 32'h2000_0600) begin
      bad++; $display("FAIL ack_redirect_word got=%b/%h/%h want=1/00000600/20000600", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    tick;
    redirect_valid = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL wrap_addr got=%b/%h want=1/fffffffc", imem_req, imem_addr);
    end
    tick;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || pcplus4 !== 32'h0) begin
      bad++; $display("FAIL wrap_pcplus4 got=%b/%h/%h want=1/fffffffc/00000000", instr_valid, instr_pc, pcplus4);
    end
    instr_ready = 1'b1; mem_hold = 1'b1;
    tick;
    instr_ready = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL wrap_next got=%b/%h want=1/00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_async_reset;
    redirect_valid = 1'b1; redirect_pc = 32'h800;
    tick;
    redirect_valid = 1'b0;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++; $display("FAIL areset_drain got=%b/%h want=1/00000000", imem_req, imem_addr);
    end
    #2 reset_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0 || instr_valid !== 1'b0 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL areset_now got=%b/%b/%h want=0/0/00000040", imem_req, instr_valid, imem_addr);
    end
    mem_hold = 1'b0;
    tick;
    reset_n = 1'b1;
    tick;
    total++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin
      bad++; $display("FAIL areset_boot got=%b/%h want=1/00000040", imem_req, imem_addr);
    end
    tick;
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== 32'h8C08_0004) begin
      bad++; $display("FAIL areset_word got=%b/%h/%h want=1/00000040/8c080004", instr_valid, instr_pc, instr);
    end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_backpressure;
    test_redirect_drain;
    test_hold_redirect;
    test_wrap;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
